// File: rtl/ptp_ts_queue.sv
// Timestamp record FIFO behind the PTP parser: buffers {seqid, msgid, time}
// records for the host, with occupancy flags and a saturating drop counter.
module ptp_ts_queue #(
  parameter int AW    = 4,
  parameter int DW    = 52,
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ptp_found,
  input  logic [DW-1:0]    ptp_infor,
  input  logic             q_flush,
  input  logic             rd_req,
  output logic [DW-1:0]    rd_data,
  output logic             rd_valid,
  output logic [AW:0]      q_cnt,
  output logic             q_empty,
  output logic             q_full,
  output logic [OVF_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [DW-1:0]    mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [DW-1:0]    rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  logic             pop, push, drop, mem_we;

  // Clear wins over a same-cycle drop, but that drop still counts as the first one.
  function automatic logic [OVF_W-1:0] ovf_next(input logic [OVF_W-1:0] cur,
                                                input logic clr,
                                                input logic drp);
    if (clr)
      return drp ? OVF_W'(1) : '0;
    if (drp && (cur != '1))
      return cur + 1'b1;
    return cur;
  endfunction

  always_comb begin
    pop    = rd_req && (cnt_q != '0);
    // A full queue still accepts a record when a pop frees a slot in the same cycle.
    push   = ptp_found && ((cnt_q < DEPTH_C) || pop);
    drop   = ptp_found && !push && !q_flush;
    mem_we = push && !q_flush && !rst;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    ovf_d      = ovf_next(ovf_q, ovf_clr, drop);

    if (q_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (pop) begin
        rd_data_d  = mem[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + 1'b1;
      end
      if (push)
        wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !pop)
        cnt_d = cnt_q + 1'b1;
      else if (pop && !push)
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_ptr_q] <= ptp_infor;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign q_cnt    = cnt_q;
  assign q_empty  = (cnt_q == '0);
  assign q_full   = (cnt_q == DEPTH_C);
  assign ovf_cnt  = ovf_q;

endmodule
